// File: rtl/srl_tap_pkg.sv
// Shared sizing, types and helpers for the addressable SRL tap reader.
package srl_tap_pkg;

    localparam int unsigned N_DEF     = 8;
    localparam int unsigned DEPTH_DEF = 32;

    // Address/fill width: must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int unsigned tap_aw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned AW_DEF  = tap_aw(DEPTH_DEF);
    localparam int unsigned TAP_MAX = DEPTH_DEF - 1;

    typedef logic [AW_DEF-1:0] tap_addr_t;

endpackage

// File: rtl/srl_fill_counter.sv
// Saturating fill-level counter for the shift chain; clr beats e for old data.
module srl_fill_counter
    import srl_tap_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = tap_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          e_i,
    input  logic          clr_i,
    output logic [AW-1:0] fill_o,
    output logic          full_o
);

    logic [AW-1:0] fill_q, fill_d;
    logic          full_q, full_d;

    always_comb begin
        fill_d = fill_q;
        if (clr_i) begin
            // A word shifted in alongside clr is the first valid entry.
            fill_d = e_i ? AW'(1) : '0;
        end else if (e_i && (fill_q != AW'(DEPTH))) begin
            fill_d = fill_q + AW'(1);
        end
        full_d = (fill_d == AW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
            full_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
            full_q <= full_d;
        end
    end

    assign fill_o = fill_q;
    assign full_o = full_q;

endmodule

// File: rtl/srl_tap_reader.sv
// Addressable shift-register delay line with fill-masked tap read.
// Define SRL_TAP_OUTREG_EN to register y/y_vld (one cycle read latency).
module srl_tap_reader
    import srl_tap_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = tap_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  a,
    input  logic          e,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  y,
    output logic          y_vld,
    output logic [AW-1:0] fill,
    output logic          full
);

    logic [N-1:0] chain_q [DEPTH];
    logic [N-1:0] tap_c;
    logic [N-1:0] y_c;
    logic         y_vld_c;

    // No reset on the chain so synthesis can map it onto SRL primitives.
    always_ff @(posedge clk) begin
        if (e) begin
            chain_q[0] <= a;
            for (int k = 1; k < DEPTH; k++) begin
                chain_q[k] <= chain_q[k-1];
            end
        end
    end

    srl_fill_counter #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fill (
        .clk    (clk),
        .rst_n  (rst_n),
        .e_i    (e),
        .clr_i  (clr),
        .fill_o (fill),
        .full_o (full)
    );

    // Compare-based mux never indexes past the chain for addr >= DEPTH.
    always_comb begin
        tap_c = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (addr == AW'(k)) begin
                tap_c = chain_q[k];
            end
        end
        y_vld_c = (addr < fill);
        y_c     = y_vld_c ? tap_c : '0;
    end

`ifdef SRL_TAP_OUTREG_EN
    logic [N-1:0] y_q;
    logic         y_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            y_vld_q <= 1'b0;
        end else begin
            y_q     <= y_c;
            y_vld_q <= y_vld_c;
        end
    end

    assign y     = y_q;
    assign y_vld = y_vld_q;
`else
    assign y     = y_c;
    assign y_vld = y_vld_c;
`endif

endmodule

// File: doc/srl_tap_reader.md
Name: srl_tap_reader

Overview:
- Addressable shift-register delay line: the read side of the SRL shift chains used in Xilinx SRL inference tests.
- Writer side shifts an N-bit word in on each clock-enable. Reader side selects any tap by dynamic address, as SRLC32E A[4:0] does.
- Tracks fill level so the reader never sees stale or reset-garbage taps.
- Used as the DUT (RTL vs. synth netlist) in the synth_xilinx_srl dynamic-tap testcase.

Parameters:
- N, 8, data width in bits
- DEPTH, 32, number of shift stages (1..128)
- AW, $clog2(DEPTH+1), address and fill-counter width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- a  input  N  shift-in data word
- e  input  1  shift enable (clock enable of the chain)
- clr  input  1  synchronous clear of fill level
- addr  input  AW  tap select; 0 = newest word
- y  output  N  selected tap data; 0 when not valid
- y_vld  output  1  selected tap holds written data
- fill  output  AW  count of valid stages, saturates at DEPTH
- full  output  1  fill == DEPTH

Behaviour:
- Clocking and reset
  - One clock. Reset is asynchronous and active-low; clock port clk, reset port rst_n.
  - The shift chain has NO reset and no init, so it can map to SRL primitives.
  - Only the fill counter, and the output register when enabled, are reset.
- Reset values: fill=0, full=0, y_vld=0, y=0. Chain contents are retained through reset but masked.
- Shift rule: on posedge clk with e=1, chain[0]<=a and chain[k]<=chain[k-1] for k=1..DEPTH-1. Chain holds when e=0.
- Fill counter
  - e=1, clr=0: fill<=min(fill+1, DEPTH). Saturates; no wrap past DEPTH.
  - clr=1, e=0: fill<=0.
  - clr=1, e=1: shift happens and fill<=1. The new word counts, clr wins for old data.
  - e=0, clr=0: hold.
- Read path
  - y_vld = (addr < fill).
  - y = y_vld ? chain[addr] : 0.
  - addr >= DEPTH gives y_vld=0, y=0. No X propagation, no out-of-range indexing.
  - Combinational from addr and the chain. Zero-cycle read latency, so a word written at edge t is readable at addr 0 right after edge t.
- full = (fill == DEPTH).
- Reset mid-operation: fill drops to 0 asynchronously and y/y_vld go 0 immediately. The first shift after release gives fill=1.
- Timing: inputs sampled at posedge; outputs must be stable before the negedge checker sample.

Optional Feature:
- Macro: SRL_TAP_OUTREG_EN.
- Defined:
  - y and y_vld are registered, mapping to the SRL + FF pair. Read latency is 1 cycle: the value reflects addr and chain as of the previous edge.
  - Output register reset to 0 by rst_n, and updates every cycle regardless of e.
- Undefined: combinational read as above.
- fill and full are unaffected in both cases.

Decomposition:
- Shared package srl_tap_pkg holds:
  - default N/DEPTH localparams
  - a function for AW
  - typedef tap_addr_t sized AW
  - constant TAP_MAX = DEPTH-1
- One sub-module, srl_fill_counter: saturating up-counter with clr/e priority, async active-low reset, exporting fill and full.
- The chain and read mux stay in the top so tools infer the SRL directly.

Test Plan (N=8, DEPTH=32):
- Reset release, e=0, addr=0 -> y=0, y_vld=0, fill=0 on all cycles.
- Shift 0x01..0x05 with e=1, then addr=0..4 -> y=0x05,0x04,0x03,0x02,0x01 with y_vld=1; addr=5 -> y=0, y_vld=0.
- 40 shifts of 0x00..0x27 -> fill saturates at 32, full=1; addr=31 -> y=0x08, addr=0 -> y=0x27.
- e toggling randomly vs. a golden model with the same e sequence -> y matches the model at every negedge for all addr 0..31.
- clr=1 with e=1 and a=0xAA at a full chain -> fill=1, addr=0 y=0xAA, addr=1 y=0/y_vld=0. clr alone -> fill=0.
- rst_n pulsed low mid-run -> y/y_vld/fill go 0 without waiting for an edge. With SRL_TAP_OUTREG_EN, a repeat of scenario 2 gives each value one cycle later.
